// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner with ghost rejection, frame debouncing and one-cycle key_valid.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scanner #(
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned REPEAT_DELAY   = 250,
    parameter int unsigned REPEAT_RATE    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_clk,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    if (DEBOUNCE_SCANS < 2 || REPEAT_RATE == 0 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
        $error("keypad_matrix_scanner: unsupported parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StDebounce, StHeld, StRelease} state_e;

    logic [1:0]      scan_sync_q, scan_sync_d;
    logic            scan_prev_q, scan_prev_d;
    logic [3:0]      row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [1:0]      acc_cnt_q, acc_cnt_d;
    logic [3:0]      acc_code_q, acc_code_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;

    logic       tick, frame_done, is_single, is_none, accept;
    logic [1:0] col_low, col_row;
    logic [2:0] frame_low;
    logic [3:0] frame_code;

    always_comb begin
        scan_sync_d = {scan_sync_q[0], scan_clk};
        scan_prev_d = scan_sync_q[1];
        row_s1_d    = row_n;
        row_s2_d    = row_s1_q;
        tick        = scan_sync_q[1] & ~scan_prev_q;
    end

    // Low-row count for the column being sampled, saturating at 2 (ghost / multi-key).
    always_comb begin
        col_low = 2'd0;
        col_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2_q[r]) begin
                col_row = 2'(r);
                if (col_low != 2'd2) col_low = col_low + 2'd1;
            end
        end
        frame_low  = {1'b0, acc_cnt_q} + {1'b0, col_low};
        frame_done = tick && (col_idx_q == 2'd3);
        is_single  = (frame_low == 3'd1);
        is_none    = (frame_low == 3'd0);
        frame_code = (col_low == 2'd1) ? {col_row, col_idx_q} : acc_code_q;
    end

    always_comb begin
        col_idx_d  = col_idx_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (tick) begin
            col_idx_d = col_idx_q + 2'd1;
            if (frame_done) begin
                acc_cnt_d  = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                acc_cnt_d = (frame_low >= 3'd2) ? 2'd2 : frame_low[1:0];
                if (col_low == 2'd1) acc_code_d = {col_row, col_idx_q};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        key_code_d = key_code_q;
        accept     = 1'b0;
        cnt_inc    = (cnt_q < DebMax) ? cnt_q + CntOne : cnt_q;
        if (frame_done) begin
            unique case (state_q)
                StIdle: begin
                    if (is_single) begin
                        state_d = StDebounce;
                        cand_d  = frame_code;
                        cnt_d   = CntOne;
                    end
                end
                StDebounce: begin
                    if (is_single && frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebMax) begin
                            state_d    = StHeld;
                            key_code_d = cand_q;
                            accept     = 1'b1;
                            cnt_d      = '0;
                        end
                    end else if (is_single) begin
                        cand_d = frame_code;
                        cnt_d  = CntOne;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StHeld: begin
                    if (!(is_single && frame_code == key_code_q)) begin
                        state_d = StRelease;
                        cnt_d   = is_none ? CntOne : '0;
                    end
                end
                StRelease: begin
                    if (is_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebMax) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end else if (is_single && frame_code == key_code_q) begin
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned     RepW      = $clog2(REPEAT_DELAY + 1);
    localparam logic [RepW-1:0] RepMax    = RepW'(REPEAT_DELAY);
    localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DELAY - REPEAT_RATE);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic            rep_fire;

    // Survives a RELEASE->HELD bounce; only a fall back to IDLE/DEBOUNCE clears it.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        rep_inc   = rep_cnt_q + RepW'(1);
        if (frame_done) begin
            if (state_q == StHeld && state_d == StHeld) begin
                if (rep_inc == RepMax) begin
                    rep_fire  = 1'b1;
                    rep_cnt_d = RepReload;
                end else begin
                    rep_cnt_d = rep_inc;
                end
            end else if (state_d == StIdle || state_d == StDebounce) begin
                rep_cnt_d = '0;
            end
        end
        key_valid_d = accept | rep_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end
`else
    always_comb key_valid_d = accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_sync_q <= 2'b00;
            scan_prev_q <= 1'b0;
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            col_idx_q   <= 2'd0;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= 4'd0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            scan_sync_q <= scan_sync_d;
            scan_prev_q <= scan_prev_d;
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            col_idx_q   <= col_idx_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        col_n     = ~(4'b0001 << col_idx_q);
        key_code  = key_code_q;
        key_valid = key_valid_q;
        key_held  = (state_q == StHeld) || (state_q == StRelease);
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a key-matrix model drives row_n from col_n and
// expected key_valid events (code + frame number) are queued at stimulus time.
module tb_keypad_matrix_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_clk = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] code;
        int         frame;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         frame_no = 0;
    logic [3:0] prev_col = 4'b1110;
    bit         col_check_en = 1'b0;

    always #5 clk = ~clk;
    always #80 scan_clk = ~scan_clk;

    keypad_matrix_scanner #(
        .DEBOUNCE_SCANS(3),
        .REPEAT_DELAY  (4),
        .REPEAT_RATE   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_clk (scan_clk),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (prev_col == 4'b0111 && col_n == 4'b1110) frame_no++;
        if (col_check_en && col_n !== prev_col) begin
            checks++;
            if (col_n !== {prev_col[2:0], prev_col[3]}) begin
                errors++;
                $display("FAIL col_rotate: col_n=%b after %b, required %b",
                         col_n, prev_col, {prev_col[2:0], prev_col[3]});
            end
        end
        prev_col = col_n;
        if (key_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL valid_unexpected: key_valid=1 code=%h frame=%0d, required no pulse",
                         key_code, frame_no);
            end else begin
                mon_e = exp_q.pop_front();
                if (key_code !== mon_e.code || frame_no != mon_e.frame) begin
                    errors++;
                    $display("FAIL valid_event: code=%h frame=%0d, required code=%h frame=%0d",
                             key_code, frame_no, mon_e.code, mon_e.frame);
                end
            end
        end
    end

    task automatic wait_frames(input int n);
        int start;
        int t;
        for (int i = 0; i < n; i++) begin
            start = frame_no;
            t = 0;
            while (frame_no == start && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (frame_no == start) begin
                checks++;
                errors++;
                $display("FAIL frame_timeout: no frame boundary in %0d cycles, required one", t);
            end
        end
    endtask

    task automatic push_exp(input logic [3:0] code, input int frame);
        exp_t e;
        e.code  = code;
        e.frame = frame;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        keys = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (col_n !== 4'b1110) begin
            errors++; $display("FAIL reset_col_n: got %b, required 1110", col_n);
        end
        if (key_code !== 4'h0) begin
            errors++; $display("FAIL reset_key_code: got %h, required 0", key_code);
        end
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_key_valid: got %b, required 0", key_valid);
        end
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL reset_key_held: got %b, required 0", key_held);
        end
        rst = 1'b0;
        col_check_en = 1'b1;
        wait_frames(10);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL idle_key_held: got %b, required 0", key_held);
        end
    endtask

    task automatic test_single_press();
        wait_frames(1);
        keys = 16'h0040;                 // row1/col2
        push_exp(4'h6, frame_no + 3);
        wait_frames(5);
        checks += 3;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL press_held: got %b, required 1", key_held);
        end
        if (key_code !== 4'h6) begin
            errors++; $display("FAIL press_code: got %h, required 6", key_code);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL press_missing_valid: pending=%0d, required 0", exp_q.size());
        end
        keys = 16'h0000;
        wait_frames(2);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL release_early_held: got %b, required 1", key_held);
        end
        wait_frames(1);
        checks += 2;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL release_held: got %b, required 0", key_held);
        end
        if (key_code !== 4'h6) begin
            errors++; $display("FAIL release_code_hold: got %h, required 6", key_code);
        end
    endtask

    task automatic test_short_press();
        keys = 16'h1000;                 // row3/col0
        wait_frames(2);
        keys = 16'h0000;
        wait_frames(3);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL short_held: got %b, required 0", key_held);
        end
        keys = 16'h1000;
        push_exp(4'hC, frame_no + 3);
        wait_frames(3);
        checks += 2;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL short_repress_held: got %b, required 1", key_held);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL short_repress_valid: pending=%0d, required 0", exp_q.size());
        end
        keys = 16'h0000;
        wait_frames(3);
    endtask

    task automatic test_multi();
        keys = 16'h0003;                 // row0/col0 + row0/col1
        wait_frames(5);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL multi_held: got %b, required 0", key_held);
        end
        keys = 16'h0000;
        wait_frames(1);
    endtask

    task automatic test_bounce();
        keys = 16'h8000;                 // row3/col3
        push_exp(4'hF, frame_no + 3);
        wait_frames(3);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL bounce_accept_held: got %b, required 1", key_held);
        end
        keys = 16'h0000;
        wait_frames(1);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL bounce_gap_held: got %b, required 1", key_held);
        end
        keys = 16'h8000;
        wait_frames(3);
        checks += 2;
        if (key_held !== 1'b1 || key_code !== 4'hF) begin
            errors++;
            $display("FAIL bounce_repress: held=%b code=%h, required held=1 code=f",
                     key_held, key_code);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL bounce_pending: pending=%0d, required 0", exp_q.size());
        end
        keys = 16'h0000;
        wait_frames(3);
    endtask

    task automatic test_reset_mid_debounce();
        keys = 16'h0020;                 // row1/col1
        wait_frames(2);
        repeat (20) @(negedge clk);
        col_check_en = 1'b0;
        rst  = 1'b1;
        keys = 16'h0000;
        @(negedge clk);
        checks += 4;
        if (col_n !== 4'b1110) begin
            errors++; $display("FAIL midrst_col_n: got %b, required 1110", col_n);
        end
        if (key_code !== 4'h0) begin
            errors++; $display("FAIL midrst_key_code: got %h, required 0", key_code);
        end
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_key_valid: got %b, required 0", key_valid);
        end
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL midrst_key_held: got %b, required 0", key_held);
        end
        rst = 1'b0;
        wait_frames(1);
        col_check_en = 1'b1;
        wait_frames(3);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL midrst_after_held: got %b, required 0", key_held);
        end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int base;
        keys = 16'h0200;                 // row2/col1
        base = frame_no;
        push_exp(4'h9, base + 3);
        push_exp(4'h9, base + 7);
        push_exp(4'h9, base + 9);
        push_exp(4'h9, base + 11);
        wait_frames(12);
        keys = 16'h0000;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL repeat_pending: pending=%0d, required 0", exp_q.size());
        end
        wait_frames(3);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL repeat_release_held: got %b, required 0", key_held);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_short_press();
        test_multi();
        test_bounce();
        test_reset_mid_debounce();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_pending: pending=%0d, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
